// File: rtl/rb_pkg.sv
// Shared types and helpers for the rb_* stream blocks.
package rb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Increment an index modulo n without producing values >= n.
  function automatic int wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rb_if.sv
// Valid/ready stream link shared by the rb_* blocks.
// A beat transfers on a rising edge where valid && ready; once valid is high
// the master holds valid and data stable until that transfer happens.
interface rb_if #(
  parameter type data_t = logic
);
  logic  valid;
  logic  ready;
  data_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rb_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  function automatic logic [IW-1:0] rot(logic [IW-1:0] p, int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest valid index wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[rot(ptr, k)]) begin
        grant = rot(ptr, k);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rb_arbiter.sv
// N-way round-robin arbiter with burst locking and a single registered output stage.
module rb_arbiter
  import rb_pkg::*;
#(
  parameter type data_t = logic,
  parameter int  N      = 4,
  parameter int  BURST  = 4,
  parameter int  IW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  data_t         in_data [N],
  rb_if.master          o_bus,
  output logic [IW-1:0] o_src,
  output logic          busy,
  output arb_state_t    dbg_state
);

  localparam int CW = $clog2(BURST + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] pick, sel;
  logic          pick_any, owner_live, load, accept;
  logic          out_valid_q;
  logic [IW-1:0] out_src_q;
  data_t         out_data_q;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .valid (in_valid),
    .ptr   (ptr_q),
    .grant (pick),
    .any   (pick_any)
  );

  assign owner_live = (state_q == LOCK) && in_valid[owner_q];
  assign sel        = owner_live ? owner_q : pick;
  assign load       = !out_valid_q || o_bus.ready;
  // rst_n gates accept so nothing is granted while reset is held.
  assign accept     = rst_n && load && (owner_live || pick_any);

  always_comb begin
    in_ready      = '0;
    in_ready[sel] = accept;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    // Owner went idle: release first, a same-cycle grant to another requester
    // is then handled exactly like a grant from IDLE.
    if ((state_q == LOCK) && !owner_live) begin
      state_d = IDLE;
      ptr_d   = IW'(wrap_inc(int'(owner_q), N));
      cnt_d   = '0;
    end
    if (accept) begin
      if (owner_live) begin
        if (int'(cnt_q) + 1 >= BURST) begin
          state_d = IDLE;
          ptr_d   = IW'(wrap_inc(int'(owner_q), N));
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (BURST == 1) begin
        ptr_d = IW'(wrap_inc(int'(sel), N));
      end else begin
        state_d = LOCK;
        owner_d = sel;
        cnt_d   = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (load) begin
        out_valid_q <= accept;
        if (accept) out_src_q <= sel;
      end
    end
  end

  // Payload needs no reset; valid qualifies it.
  always_ff @(posedge clk) begin
    if (accept) out_data_q <= in_data[sel];
  end

  assign o_bus.valid = out_valid_q;
  assign o_bus.data  = out_data_q;
  assign o_src       = out_src_q;
  assign busy        = (state_q == LOCK);
  assign dbg_state   = state_q;

endmodule
